matrix_row_scanner: RTL
=======================

Name: matrix_row_scanner

Overview:
Parameterised row driver for the bath heater LED dot-matrix. Successor to the fixed 8-row scanner, generalised in:
- row count
- dwell-time prescaler
- anti-ghosting blanking
- per-row on-time (brightness) control
- forward, reverse and lamp-test modes

It also supplies the row index and frame/row strobes so the column-data logic fetches pixel data in lockstep.

Parameters:
ROWS, 8, number of matrix rows; width of led_row
IDX_W, 3, width of row_idx; 2^IDX_W >= ROWS required
DIV_W, 16, width of dwell/on-time counters
BLANK_CYC, 2, cycles all rows held inactive at start of each row period; 0..2^DIV_W-1
ACTIVE_LOW, 1, 1: driven row = 0, others = 1; 0: driven row = 1, others = 0

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable
mode  input  2  00 off, 01 forward scan, 10 reverse scan, 11 lamp test
div  input  DIV_W  row period minus 1 (period = div+1 cycles)
on_cyc  input  DIV_W  end of drive window within the row period (brightness)
led_row  output  ROWS  row drive, one-hot at active level
row_idx  output  IDX_W  index of the row whose period is current
row_start  output  1  1-cycle pulse, cycle 0 of every row period
frame_start  output  1  1-cycle pulse, cycle 0 of the first row of a frame
blank  output  1  high whenever no row is driven

Behaviour:
Reset and inactive level:
- All outputs registered.
- INACT = all ones if ACTIVE_LOW, else all zeros.
- Reset values: led_row=INACT, row_idx=0, row_start=0, frame_start=0, blank=1, state=IDLE, dwell counter=0.

States:
- IDLE: led_row=INACT, blank=1, pulses 0.
  - Exit when en=1 and mode!=00 is sampled.
  - mode 01/10: the next cycle is cycle 0 of the first row period.
  - mode 11: enter TEST next cycle.
- SCAN: dwell counter d runs 0..div_l, then wraps to 0 and advances the row.
  - div and on_cyc are latched into div_l and on_l at d=0 of every row period; mid-period changes have no effect.
- TEST: all ROWS bits at active level, blank=0, row_idx=0, no pulses.

Scan order:
- Forward: 0,1,...,ROWS-1, wrap to 0.
- Reverse: ROWS-1,...,0, wrap to ROWS-1.
- The first row of a frame is 0 (forward) or ROWS-1 (reverse); frame_start fires at d=0 of that row, together with row_start.
- row_idx is held for the whole row period and changes exactly on the cycle row_start is high.

Drive window, output view, cycle k of a row period:
- row row_idx is driven iff BLANK_CYC <= k < min(on_l, div_l+1); otherwise led_row=INACT and blank=1.
- on_l <= BLANK_CYC: row never lit; scanning and strobes continue.
- on_l > div_l: drive runs to the end of the period, and blanking comes only from BLANK_CYC of the next row.
- div=0: 1-cycle periods; rows lit only if BLANK_CYC=0 and on_cyc>=1.

Mode and enable changes:
- en=0 or mode=00 sampled in SCAN/TEST: IDLE on the next edge, outputs go inactive immediately, and the row and dwell counters clear.
- 01<->10 while in SCAN: takes effect only at the frame boundary. The current frame completes in the old direction; the next frame starts at the new first row.
- 11 sampled in SCAN: TEST next cycle.
- 01/10 sampled in TEST: restart a fresh frame next cycle with frame_start, as from IDLE.

Asynchronous reset mid-frame: all state returns to reset values immediately; the scan restarts from IDLE.

Test Plan:
1. ROWS=8, ACTIVE_LOW=1, BLANK_CYC=2, div=9, on_cyc=10, mode=01 -> each row period is 10 cycles: 2 cycles 8'hFF, then 8 cycles active; led_row sequence FE,FD,...,7F; frame_start every 80 cycles.
2. Same setup, mode=10 -> first row is 7F, then BF,...,FE; row_idx 7..0; frame_start at row_idx=7.
3. div=9, on_cyc=5 -> per period: 2 blank, 3 driven (k=2..4), 5 blank. on_cyc=1 -> led_row stays FF, while row_start still pulses every 10 cycles.
4. Switch mode 01->10 at row 3 -> rows 4..7 still forward, then next frame starts at row 7 with frame_start; switch to 11 -> led_row=8'h00 next cycle, blank=0.
5. Deassert en mid-period -> led_row=FF, blank=1 next cycle; re-enable -> frame_start with row 0 one cycle after en sampled.
6. ROWS=12, IDX_W=4, ACTIVE_LOW=0, BLANK_CYC=0, div=0, on_cyc=1 -> one row per cycle, 12'h001..12'h800, blank never high; async rst mid-frame -> 12'h000, row_idx=0 immediately.

Source files
------------

// File: rtl/matrix_row_scanner.sv
// Row driver for the heater LED dot-matrix: scans rows with a programmable dwell,
// anti-ghost blanking and on-time window, and emits row/frame strobes for the column fetch.
module matrix_row_scanner #(
   parameter int ROWS       = 8,
   parameter int IDX_W      = 3,
   parameter int DIV_W      = 16,
   parameter int BLANK_CYC  = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic [DIV_W-1:0] on_cyc,
   output logic [ROWS-1:0]  led_row,
   output logic [IDX_W-1:0] row_idx,
   output logic             row_start,
   output logic             frame_start,
   output logic             blank
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_TEST = 2'd2
   } state_t;

   localparam logic [ROWS-1:0]  INACT    = (ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
   localparam logic [DIV_W-1:0] BLANK_D  = DIV_W'(BLANK_CYC);

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] d_reg, d_next;
   logic [IDX_W-1:0] row_reg, row_next;
   logic             dir_reg, dir_next;
   logic [DIV_W-1:0] div_l_reg, div_l_next;
   logic [DIV_W-1:0] on_l_reg, on_l_next;

   logic [ROWS-1:0]  led_row_reg, led_row_next;
   logic [IDX_W-1:0] row_idx_reg, row_idx_next;
   logic             row_start_reg, row_start_next;
   logic             frame_start_reg, frame_start_next;
   logic             blank_reg, blank_next;

   logic             scan_req, test_req, mode_rev;
   logic             new_frame;
   logic [IDX_W-1:0] frame_last;
   logic             past_blank;
   logic             drive_ok;
   logic [ROWS-1:0]  row_active;

   assign scan_req   = en && (mode == 2'b01 || mode == 2'b10);
   assign test_req   = en && (mode == 2'b11);
   assign mode_rev   = (mode == 2'b10);
   // dir_reg is the direction of the frame in progress; mode only steers the next frame
   assign frame_last = dir_reg ? '0 : LAST_ROW;

   always_comb begin
      state_next = state_reg;
      d_next     = d_reg;
      row_next   = row_reg;
      dir_next   = dir_reg;
      div_l_next = div_l_reg;
      on_l_next  = on_l_reg;
      new_frame  = 1'b0;

      case (state_reg)
         ST_SCAN: begin
            if (scan_req) begin
               if (d_reg == div_l_reg) begin
                  d_next = '0;
                  if (row_reg == frame_last) begin
                     new_frame = 1'b1;
                  end else if (dir_reg) begin
                     row_next = row_reg - IDX_W'(1);
                  end else begin
                     row_next = row_reg + IDX_W'(1);
                  end
               end else begin
                  d_next = d_reg + DIV_W'(1);
               end
            end else if (test_req) begin
               state_next = ST_TEST;
               d_next     = '0;
               row_next   = '0;
            end else begin
               state_next = ST_IDLE;
               d_next     = '0;
               row_next   = '0;
            end
         end
         default: begin
            d_next   = '0;
            row_next = '0;
            if (scan_req) begin
               new_frame = 1'b1;
            end else if (test_req) begin
               state_next = ST_TEST;
            end else begin
               state_next = ST_IDLE;
            end
         end
      endcase

      if (new_frame) begin
         state_next = ST_SCAN;
         d_next     = '0;
         dir_next   = mode_rev;
         row_next   = mode_rev ? LAST_ROW : '0;
      end

      // Period parameters are captured only on entry to cycle 0 of a row
      if (state_next == ST_SCAN && d_next == '0) begin
         div_l_next = div;
         on_l_next  = on_cyc;
      end
   end

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign past_blank = 1'b1;
      end else begin : g_blank
         assign past_blank = (d_next >= BLANK_D);
      end
   endgenerate

   // k never exceeds div_l, so the period end already bounds the window
   assign drive_ok = past_blank && (d_next < on_l_next);

   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
         assign row_active[gi] = (row_next == IDX_W'(gi)) ? ~INACT[gi] : INACT[gi];
      end
   endgenerate

   always_comb begin
      led_row_next     = INACT;
      row_idx_next     = '0;
      row_start_next   = 1'b0;
      frame_start_next = 1'b0;
      blank_next       = 1'b1;
      case (state_next)
         ST_SCAN: begin
            row_idx_next     = row_next;
            row_start_next   = (d_next == '0);
            frame_start_next = new_frame;
            if (drive_ok) begin
               led_row_next = row_active;
               blank_next   = 1'b0;
            end
         end
         ST_TEST: begin
            led_row_next = ~INACT;
            blank_next   = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         d_reg           <= '0;
         row_reg         <= '0;
         dir_reg         <= 1'b0;
         div_l_reg       <= '0;
         on_l_reg        <= '0;
         led_row_reg     <= INACT;
         row_idx_reg     <= '0;
         row_start_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         blank_reg       <= 1'b1;
      end else begin
         state_reg       <= state_next;
         d_reg           <= d_next;
         row_reg         <= row_next;
         dir_reg         <= dir_next;
         div_l_reg       <= div_l_next;
         on_l_reg        <= on_l_next;
         led_row_reg     <= led_row_next;
         row_idx_reg     <= row_idx_next;
         row_start_reg   <= row_start_next;
         frame_start_reg <= frame_start_next;
         blank_reg       <= blank_next;
      end
   end

   assign led_row     = led_row_reg;
   assign row_idx     = row_idx_reg;
   assign row_start   = row_start_reg;
   assign frame_start = frame_start_reg;
   assign blank       = blank_reg;

endmodule
